spi_boot_ctrl: RTL and testbench

Bootstrap sequencer that drives the `spi` flash master to copy a block of 32-bit words from SPI flash into on-chip memory. It generates one READ command per word on the `spi` command port and waits for the `spi` completion strobe. It writes each returned word to a simple memory write port and reports busy, done and error status to the boot FSM. It sits between the top-level boot control and the `spi` instance, and is that instance's only master.

---
 rtl/spi_boot_ctrl.sv | 140 ++++++++++++++
 tb/tb_spi_boot_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_boot_ctrl.sv
// Boot sequencer: copies boot_word_count_i 32-bit words from SPI flash into
// on-chip memory, one READ command per word, with a per-word timeout.
module spi_boot_ctrl #(
   parameter logic [7:0]  READ_OPCODE = 8'h03,
   parameter logic [8:0]  STATUS_READ = 9'h180,
   parameter int unsigned TIMEOUT     = 4096,
   parameter int unsigned MEM_AW      = 16
) (
   input  logic              boot_clk_i,
   input  logic              boot_rst_i,
   input  logic              boot_start_i,
   input  logic [23:0]       boot_base_addr_i,
   input  logic [15:0]       boot_word_count_i,
   output logic              spi_init_o,
   output logic [8:0]        spi_statusreg_o,
   output logic [47:0]       spi_cmd_o,
   input  logic              spi_initdone_i,
   input  logic [31:0]       spi_rdata_i,
   output logic              mem_we_o,
   output logic [MEM_AW-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   output logic              boot_busy_o,
   output logic              boot_done_o,
   output logic              boot_error_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT, S_WRITE, S_NEXT, S_DONE, S_ERR
   } state_t;

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   state_t            state_q, state_n;
   logic [23:0]       addr_q, addr_n;
   logic [15:0]       cnt_q, cnt_n, idx_q, idx_n, tmo_q, tmo_n;
   logic              init_n, we_n, busy_n, done_n, err_n;
   logic [8:0]        status_n;
   logic [47:0]       cmd_n;
   logic [MEM_AW-1:0] maddr_n;
   logic [31:0]       wdata_n;
   logic              at_rest, last_word;

   assign at_rest   = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR);
   assign last_word = (idx_q == cnt_q - 16'd1);

   always_ff @(posedge boot_clk_i) begin
      if (boot_rst_i) begin
         state_q         <= S_IDLE;
         addr_q          <= '0;
         cnt_q           <= '0;
         idx_q           <= '0;
         tmo_q           <= '0;
         spi_init_o      <= 1'b0;
         spi_statusreg_o <= '0;
         spi_cmd_o       <= '0;
         mem_we_o        <= 1'b0;
         mem_addr_o      <= '0;
         mem_wdata_o     <= '0;
         boot_busy_o     <= 1'b0;
         boot_done_o     <= 1'b0;
         boot_error_o    <= 1'b0;
      end else begin
         state_q         <= state_n;
         addr_q          <= addr_n;
         cnt_q           <= cnt_n;
         idx_q           <= idx_n;
         tmo_q           <= tmo_n;
         spi_init_o      <= init_n;
         spi_statusreg_o <= status_n;
         spi_cmd_o       <= cmd_n;
         mem_we_o        <= we_n;
         mem_addr_o      <= maddr_n;
         mem_wdata_o     <= wdata_n;
         boot_busy_o     <= busy_n;
         boot_done_o     <= done_n;
         boot_error_o    <= err_n;
      end
   end

   always_comb begin
      state_n = state_q;
      case (state_q)
         S_IDLE, S_DONE, S_ERR:
            if (boot_start_i) state_n = (boot_word_count_i == 16'd0) ? S_DONE : S_ISSUE;
         S_ISSUE: if (!spi_initdone_i) state_n = S_WAIT;
         // a completion in the last timeout cycle still counts as success
         S_WAIT: begin
            if (spi_initdone_i)         state_n = S_WRITE;
            else if (tmo_q == TO_LAST)  state_n = S_ERR;
         end
         // WRITE spans two cycles: one to raise the strobe, one while it is out
         S_WRITE: if (mem_we_o) state_n = S_NEXT;
         S_NEXT:  state_n = last_word ? S_DONE : S_ISSUE;
         default: state_n = S_IDLE;
      endcase
   end

   always_comb begin
      addr_n   = addr_q;
      cnt_n    = cnt_q;
      idx_n    = idx_q;
      tmo_n    = tmo_q;
      status_n = spi_statusreg_o;
      cmd_n    = spi_cmd_o;
      we_n     = 1'b0;
      maddr_n  = mem_addr_o;
      wdata_n  = mem_wdata_o;
      case (state_q)
         S_ISSUE: if (!spi_initdone_i) begin
            cmd_n    = {READ_OPCODE, addr_q, 16'h0000};
            status_n = STATUS_READ;
         end
         S_WAIT: begin
            if (spi_initdone_i) wdata_n = spi_rdata_i;
            else                tmo_n   = tmo_q + 16'd1;
         end
         S_WRITE: if (!mem_we_o) begin
            we_n    = 1'b1;
            maddr_n = MEM_AW'(idx_q);
         end
         S_NEXT: if (!last_word) begin
            idx_n  = idx_q + 16'd1;
            addr_n = addr_q + 24'd4;
            tmo_n  = '0;
         end
         default: ;
      endcase
      if (at_rest && boot_start_i) begin
         addr_n = boot_base_addr_i;
         cnt_n  = boot_word_count_i;
         idx_n  = '0;
         tmo_n  = '0;
      end
      init_n = (state_n == S_WAIT);
      busy_n = !((state_n == S_IDLE) || (state_n == S_DONE) || (state_n == S_ERR));
      done_n = (state_n == S_DONE);
      err_n  = (state_n == S_ERR);
   end

endmodule

// File: tb/tb_spi_boot_ctrl.sv
// Randomized bench for spi_boot_ctrl: a flash responder with random latency
// feeds a scoreboard of expected commands and memory writes.
module tb_spi_boot_ctrl;

   localparam int          TO      = 16;
   localparam int          MAW     = 4;
   localparam logic [7:0]  READ_OP = 8'h03;
   localparam logic [8:0]  ST_RD   = 9'h180;

   logic            boot_clk_i = 1'b0;
   logic            boot_rst_i = 1'b1;
   logic            boot_start_i = 1'b0;
   logic [23:0]     boot_base_addr_i = '0;
   logic [15:0]     boot_word_count_i = '0;
   logic            spi_init_o;
   logic [8:0]      spi_statusreg_o;
   logic [47:0]     spi_cmd_o;
   logic            spi_initdone_i = 1'b0;
   logic [31:0]     spi_rdata_i = '0;
   logic            mem_we_o;
   logic [MAW-1:0]  mem_addr_o;
   logic [31:0]     mem_wdata_o;
   logic            boot_busy_o, boot_done_o, boot_error_o;

   spi_boot_ctrl #(.READ_OPCODE(READ_OP), .STATUS_READ(ST_RD), .TIMEOUT(TO), .MEM_AW(MAW)) dut (
      .boot_clk_i(boot_clk_i), .boot_rst_i(boot_rst_i), .boot_start_i(boot_start_i),
      .boot_base_addr_i(boot_base_addr_i), .boot_word_count_i(boot_word_count_i),
      .spi_init_o(spi_init_o), .spi_statusreg_o(spi_statusreg_o), .spi_cmd_o(spi_cmd_o),
      .spi_initdone_i(spi_initdone_i), .spi_rdata_i(spi_rdata_i),
      .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .boot_busy_o(boot_busy_o), .boot_done_o(boot_done_o), .boot_error_o(boot_error_o)
   );

   always #5 boot_clk_i = ~boot_clk_i;

   int n_chk = 0, n_fail = 0;
   int cyc = 0, start_cyc = 0, err_cyc = 0, drop_chk_cyc = -1;
   int rsp_mode = 0, lat = 0, lat_lo = 0, lat_hi = 0, hold_extra = 0, hold_cnt = 0, wait_cnt = 0;
   bit served = 0;
   logic init_prev = 0, we_prev = 0, err_prev = 0;
   logic [47:0]    cmd_log[$];
   logic [MAW-1:0] wr_addr_log[$];
   logic [31:0]    wr_data_log[$], rsp_log[$], rsp_src[$];
   int             exp_we_cyc[$], rise_log[$], fall_log[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(posedge boot_clk_i) cyc++;

   // observe cycle outputs first, then drive the flash side for this cycle
   always @(negedge boot_clk_i) begin
      if (spi_init_o && !init_prev) begin
         cmd_log.push_back(spi_cmd_o);
         rise_log.push_back(cyc);
         chk("status_word", 64'(spi_statusreg_o), 64'(ST_RD));
      end
      if (drop_chk_cyc == cyc) chk("init_drop", 64'(spi_init_o), 64'd0);
      if (mem_we_o) begin
         chk("we_single", 64'(we_prev), 64'd0);
         wr_addr_log.push_back(mem_addr_o);
         wr_data_log.push_back(mem_wdata_o);
         if (exp_we_cyc.size() > 0) chk("we_timing", 64'(cyc), 64'(exp_we_cyc.pop_front()));
         else                       chk("we_unexpected", 64'd1, 64'd0);
      end
      if (boot_error_o && !err_prev) err_cyc = cyc;
      init_prev = spi_init_o;
      we_prev   = mem_we_o;
      err_prev  = boot_error_o;

      if (spi_initdone_i) begin
         if (hold_cnt > 0) hold_cnt--;
         else begin
            spi_initdone_i = 1'b0;
            fall_log.push_back(cyc);
         end
      end else if (rsp_mode == 0 && spi_init_o && !served) begin
         if (wait_cnt >= lat) begin
            spi_rdata_i    = (rsp_src.size() > 0) ? rsp_src.pop_front() : $urandom;
            spi_initdone_i = 1'b1;
            rsp_log.push_back(spi_rdata_i);
            exp_we_cyc.push_back(cyc + 2);
            drop_chk_cyc = cyc + 1;
            served   = 1;
            wait_cnt = 0;
            hold_cnt = hold_extra;
            lat      = int'($urandom_range(lat_hi, lat_lo));
         end else wait_cnt++;
      end
      if (!spi_init_o) begin
         served   = 0;
         wait_cnt = 0;
      end
   end

   task automatic set_rsp(input int mode, input int lo, input int hi, input int hold);
      rsp_mode = mode; lat_lo = lo; lat_hi = hi; lat = lo; hold_extra = hold;
   endtask

   task automatic start_boot(input logic [23:0] base, input logic [15:0] cnt);
      @(negedge boot_clk_i); #1;
      cmd_log.delete(); wr_addr_log.delete(); wr_data_log.delete(); rsp_log.delete();
      exp_we_cyc.delete(); rise_log.delete(); fall_log.delete();
      boot_base_addr_i = base; boot_word_count_i = cnt; boot_start_i = 1'b1;
      start_cyc = cyc;
      @(negedge boot_clk_i); #1;
      boot_start_i = 1'b0;
   endtask

   task automatic wait_end(input int budget);
      int n = 0;
      while (!(boot_done_o || boot_error_o) && n < budget) begin
         @(negedge boot_clk_i);
         n++;
      end
      #1;
      chk("boot_finished", 64'(boot_done_o || boot_error_o), 64'd1);
   endtask

   task automatic check_boot(input logic [23:0] base, input int count);
      logic [23:0] a;
      chk("done", 64'(boot_done_o), 64'd1);
      chk("busy", 64'(boot_busy_o), 64'd0);
      chk("error", 64'(boot_error_o), 64'd0);
      chk("n_cmds", 64'(cmd_log.size()), 64'(count));
      chk("n_writes", 64'(wr_data_log.size()), 64'(count));
      for (int i = 0; i < count; i++) begin
         a = base + 24'(4 * i);
         if (i < cmd_log.size()) chk("cmd", 64'(cmd_log[i]), 64'({READ_OP, a, 16'h0000}));
         if (i < wr_data_log.size() && i < rsp_log.size()) begin
            chk("wr_addr", 64'(wr_addr_log[i]), 64'(i % (1 << MAW)));
            chk("wr_data", 64'(wr_data_log[i]), 64'(rsp_log[i]));
         end
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk(tag, 64'({spi_init_o, spi_statusreg_o, spi_cmd_o}), 64'd0);
      chk(tag, 64'({mem_we_o, mem_addr_o, mem_wdata_o, boot_busy_o, boot_done_o, boot_error_o}), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge boot_clk_i);
      #1 boot_rst_i = 1'b0;
      @(negedge boot_clk_i);
      chk_all_zero("reset_state");

      // directed three-word copy with known flash data
      set_rsp(0, 0, 3, 0);
      rsp_src = '{32'hA5A5_0001, 32'hA5A5_0002, 32'hA5A5_0003};
      start_boot(24'h001000, 16'd3);
      chk("busy_rise", 64'(boot_busy_o), 64'd1);
      wait_end(200);
      check_boot(24'h001000, 3);
      for (int i = 0; i < 3 && i < wr_data_log.size(); i++)
         chk("known_data", 64'(wr_data_log[i]), 64'(32'hA5A5_0001 + i));
      if (rise_log.size() > 0) chk("first_init_cycle", 64'(rise_log[0]), 64'(start_cyc + 2));

      // zero-word request finishes immediately
      start_boot(24'h123456, 16'd0);
      chk("zero_done", 64'(boot_done_o), 64'd1);
      chk("zero_busy", 64'(boot_busy_o), 64'd0);
      repeat (5) @(negedge boot_clk_i);
      #1;
      chk("zero_cmds", 64'(cmd_log.size()), 64'd0);
      chk("zero_writes", 64'(wr_data_log.size()), 64'd0);

      // flash address wraps at the top of the 24-bit space
      start_boot(24'hFFFFFC, 16'd2);
      wait_end(200);
      check_boot(24'hFFFFFC, 2);

      // no completion ever arrives
      set_rsp(1, 0, 0, 0);
      start_boot(24'h000400, 16'd2);
      wait_end(200);
      chk("to_error", 64'(boot_error_o), 64'd1);
      chk("to_done", 64'(boot_done_o), 64'd0);
      chk("to_busy", 64'(boot_busy_o), 64'd0);
      chk("to_init_low", 64'(spi_init_o), 64'd0);
      chk("to_writes", 64'(wr_data_log.size()), 64'd0);
      if (rise_log.size() > 0) chk("to_latency", 64'(err_cyc - rise_log[0]), 64'(TO));
      set_rsp(0, 0, 2, 0);
      start_boot(24'h000800, 16'd1);
      chk("err_cleared", 64'(boot_error_o), 64'd0);
      wait_end(200);
      check_boot(24'h000800, 1);

      // reset while waiting on the second word
      set_rsp(0, 10, 10, 0);
      start_boot(24'h00A000, 16'd3);
      for (int n = 0; n < 200 && !(cmd_log.size() == 2 && spi_init_o); n++) @(negedge boot_clk_i);
      chk("reached_word1", 64'(cmd_log.size()), 64'd2);
      #1 boot_rst_i = 1'b1;
      @(negedge boot_clk_i);
      chk_all_zero("mid_reset");
      #1 boot_rst_i = 1'b0;
      set_rsp(0, 0, 3, 0);
      start_boot(24'h00B000, 16'd1);
      wait_end(200);
      check_boot(24'h00B000, 1);

      // start ignored while busy; done held high stalls the next issue
      set_rsp(0, 2, 2, 5);
      start_boot(24'h000200, 16'd2);
      for (int n = 0; n < 50 && !spi_init_o; n++) @(negedge boot_clk_i);
      #1;
      boot_base_addr_i = 24'hABCDEC; boot_word_count_i = 16'd5; boot_start_i = 1'b1;
      @(negedge boot_clk_i); #1 boot_start_i = 1'b0;
      wait_end(300);
      check_boot(24'h000200, 2);
      if (rise_log.size() > 1 && fall_log.size() > 0)
         chk("stall_release", 64'(rise_log[1]), 64'(fall_log[0] + 1));

      // randomized copies, some long enough to wrap the memory index
      for (int it = 0; it < 6; it++) begin
         logic [23:0] b;
         int c;
         b = 24'($urandom);
         c = int'($urandom_range(20, 1));
         set_rsp(0, 0, 4, 0);
         start_boot(b, 16'(c));
         wait_end(c * 16 + 50);
         check_boot(b, c);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
